// File: rtl/sub_pkg.sv
// Shared definitions for serial_subtractor32: datapath width, FSM state type
// and the table of slice widths that divide the 32-bit word evenly.
package sub_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Bit s is set when a slice width of s bits is supported (1,2,4,8,16,32).
    localparam logic [WIDTH:0] SLICE_LEGAL = 33'h1_0001_0116;

    function automatic bit slice_is_legal(input int s);
        if (s < 1 || s > WIDTH) begin
            return 1'b0;
        end
        return SLICE_LEGAL[s];
    endfunction

endpackage

// File: rtl/sub_slice.sv
// Combinational ripple-borrow subtractor of W bits: d = a - b - bin.
// bout is the borrow out of the most significant bit.
module sub_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);

    // Chain of full subtractors, borrow rippling from bit 0 upward.
    always_comb begin
        logic [W:0] br;
        br    = '0;
        d     = '0;
        br[0] = bin;
        for (int i = 0; i < W; i++) begin
            d[i]    = a[i] ^ b[i] ^ br[i];
            br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
        end
        bout = br[W];
    end

endmodule

// File: rtl/serial_subtractor32.sv
// serial_subtractor32: multi-cycle 32-bit subtractor D = A - B - Bin,
// processing SLICE bits per clock through one sub_slice instance.
// Handshake: inValid/inReady on the operand side, outValid/outReady on the
// result side. Optional zero flag enabled by defining SUB_ZERO_FLAG_EN.
module serial_subtractor32
    import sub_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inValid,
    output logic              inReady,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic              Bin,
    output logic              outValid,
    input  logic              outReady,
    output logic [WIDTH-1:0]  D,
    output logic              Bout,
    output logic              overFlow
`ifdef SUB_ZERO_FLAG_EN
    ,
    output logic              zero
`endif
);

    localparam int N    = WIDTH / SLICE;
    localparam int CW   = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (!slice_is_legal(SLICE)) begin : g_bad_slice
        $error("serial_subtractor32: SLICE must be 1, 2, 4, 8, 16 or 32");
    end

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  d_q, d_d;
    logic              borrow_q, borrow_d;
    logic              a31_q, a31_d;
    logic              b31_q, b31_d;
    logic              bout_q, bout_d;
    logic              ovf_q, ovf_d;
`ifdef SUB_ZERO_FLAG_EN
    logic              zero_q, zero_d;
`endif

    logic [SLICE-1:0]  sl_diff;
    logic              sl_bout;
    logic [WIDTH-1:0]  a_shr, b_shr, d_shr;

    sub_slice #(.W(SLICE)) u_slice (
        .a    (a_q[SLICE-1:0]),
        .b    (b_q[SLICE-1:0]),
        .bin  (borrow_q),
        .d    (sl_diff),
        .bout (sl_bout)
    );

    // Operands shift right by one slice; the new difference slice enters D at the top.
    if (SLICE == WIDTH) begin : g_full
        assign a_shr = '0;
        assign b_shr = '0;
        assign d_shr = sl_diff;
    end else begin : g_part
        assign a_shr = {{SLICE{1'b0}}, a_q[WIDTH-1:SLICE]};
        assign b_shr = {{SLICE{1'b0}}, b_q[WIDTH-1:SLICE]};
        assign d_shr = {sl_diff, d_q[WIDTH-1:SLICE]};
    end

    // Next-state and datapath update for IDLE / RUN / HOLD.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        d_d      = d_q;
        borrow_d = borrow_q;
        a31_d    = a31_q;
        b31_d    = b31_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
`ifdef SUB_ZERO_FLAG_EN
        zero_d   = zero_q;
`endif
        case (state_q)
            IDLE: begin
                if (inValid) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = Bin;
                    a31_d    = A[WIDTH-1];
                    b31_d    = B[WIDTH-1];
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_d      = a_shr;
                b_d      = b_shr;
                d_d      = d_shr;
                borrow_d = sl_bout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    bout_d  = sl_bout;
                    ovf_d   = (a31_q != b31_q) && (d_shr[WIDTH-1] != a31_q);
`ifdef SUB_ZERO_FLAG_EN
                    zero_d  = (d_shr == '0);
`endif
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (outReady) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            a31_q    <= 1'b0;
            b31_q    <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef SUB_ZERO_FLAG_EN
            zero_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            d_q      <= d_d;
            borrow_q <= borrow_d;
            a31_q    <= a31_d;
            b31_q    <= b31_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
`ifdef SUB_ZERO_FLAG_EN
            zero_q   <= zero_d;
`endif
        end
    end

    // inReady is gated by rst_n so every output reads 0 while reset is held.
    assign inReady  = (state_q == IDLE) && rst_n;
    assign outValid = (state_q == HOLD);
    assign D        = d_q;
    assign Bout     = bout_q;
    assign overFlow = ovf_q;
`ifdef SUB_ZERO_FLAG_EN
    assign zero     = zero_q;
`endif

endmodule

// File: tb/tb_serial_subtractor32.sv
// Testbench for serial_subtractor32: four instances (SLICE = 4, 1, 8, 32)
// driven one operation at a time, with expected results queued at acceptance
// and compared when outValid appears. Define SUB_ZERO_FLAG_EN to cover zero.
module tb_serial_subtractor32;

    localparam int NI = 4;

    typedef struct {
        logic [31:0] d;
        logic        bout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [NI];
    logic        in_ready  [NI];
    logic [31:0] a_s       [NI];
    logic [31:0] b_s       [NI];
    logic        bin_s     [NI];
    logic        out_valid [NI];
    logic        out_ready [NI];
    logic [31:0] d_s       [NI];
    logic        bout_s    [NI];
    logic        ovf_s     [NI];
`ifdef SUB_ZERO_FLAG_EN
    logic        zero_s    [NI];
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int S = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 8 : 32;
        serial_subtractor32 #(.SLICE(S)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .inValid  (in_valid[g]),
            .inReady  (in_ready[g]),
            .A        (a_s[g]),
            .B        (b_s[g]),
            .Bin      (bin_s[g]),
            .outValid (out_valid[g]),
            .outReady (out_ready[g]),
            .D        (d_s[g]),
            .Bout     (bout_s[g]),
            .overFlow (ovf_s[g])
`ifdef SUB_ZERO_FLAG_EN
            ,
            .zero     (zero_s[g])
`endif
        );
    end

    function automatic int slice_of(input int i);
        case (i)
            0:       return 4;
            1:       return 1;
            2:       return 8;
            default: return 32;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
        exp_t e;
        e.d    = a - b - {31'b0, bin};
        e.bout = ({1'b0, a} < ({1'b0, b} + {32'b0, bin}));
        e.ovf  = (a[31] != b[31]) && (e.d[31] != a[31]);
        e.zero = (e.d == 32'h0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_result(input int i, input string tag, input exp_t e);
        chk({tag, ":D"}, d_s[i], e.d);
        chk({tag, ":Bout"}, bout_s[i], e.bout);
        chk({tag, ":overFlow"}, ovf_s[i], e.ovf);
`ifdef SUB_ZERO_FLAG_EN
        chk({tag, ":zero"}, zero_s[i], e.zero);
`endif
    endtask

    task automatic chk_all_zero(input int i, input string tag);
        chk({tag, ":D"}, d_s[i], 0);
        chk({tag, ":Bout"}, bout_s[i], 0);
        chk({tag, ":overFlow"}, ovf_s[i], 0);
        chk({tag, ":outValid"}, out_valid[i], 0);
        chk({tag, ":inReady"}, in_ready[i], 0);
`ifdef SUB_ZERO_FLAG_EN
        chk({tag, ":zero"}, zero_s[i], 0);
`endif
    endtask

    // One full transaction, entered and left on a negedge with the DUT in IDLE.
    task automatic run_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic bin, input int hold, input string tag);
        int   n;
        int   lat;
        exp_t e;
        n = 32 / slice_of(i);
        chk({tag, ":inReady_idle"}, in_ready[i], 1);
        a_s[i]      = a;
        b_s[i]      = b;
        bin_s[i]    = bin;
        in_valid[i] = 1'b1;
        sb.push_back(model(a, b, bin));
        @(posedge clk);
        @(negedge clk);
        // Operands change and inValid may stay high in RUN; both must be ignored.
        in_valid[i] = (n >= 2);
        a_s[i]      = $urandom;
        b_s[i]      = $urandom;
        bin_s[i]    = ~bin;
        chk({tag, ":inReady_run"}, in_ready[i], 0);
        lat = 0;
        while (!out_valid[i] && lat < 200) begin
            @(negedge clk);
            in_valid[i] = 1'b0;
            lat++;
        end
        chk({tag, ":latency"}, lat, n);
        if (sb.size() == 0) begin
            chk({tag, ":scoreboard_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        chk_result(i, tag, e);
        chk({tag, ":inReady_hold"}, in_ready[i], 0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk({tag, ":hold_outValid"}, out_valid[i], 1);
            chk({tag, ":hold_inReady"}, in_ready[i], 0);
            chk_result(i, {tag, ":hold"}, e);
        end
        out_ready[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[i] = 1'b0;
        chk({tag, ":post_outValid"}, out_valid[i], 0);
        chk({tag, ":post_inReady"}, in_ready[i], 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        for (int i = 0; i < NI; i++) begin
            in_valid[i]  = 1'b0;
            a_s[i]       = '0;
            b_s[i]       = '0;
            bin_s[i]     = 1'b0;
            out_ready[i] = 1'b0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) chk_all_zero(i, $sformatf("reset%0d", i));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) chk($sformatf("reset%0d:inReady_rel", i), in_ready[i], 1);

        // Directed cases on SLICE=4.
        run_op(0, 32'd5,        32'd3,        1'b0, 0, "s4_5m3");
        run_op(0, 32'h00000000, 32'h00000001, 1'b0, 0, "s4_0m1");
        run_op(0, 32'h80000000, 32'h00000001, 1'b0, 0, "s4_minm1");
        run_op(0, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 0, "s4_maxmneg1");
        run_op(0, 32'h12345678, 32'h12345678, 1'b1, 0, "s4_eq_bin1");
        run_op(0, 32'h12345678, 32'h12345678, 1'b0, 5, "s4_eq_hold5");
        run_op(0, 32'hDEADBEEF, 32'h01234567, 1'b1, 0, "s4_back2back");
        run_op(0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 0, "s4_leave_nonzero");

        // Reset asserted partway through slice 3 of an operation.
        chk("rst_mid:inReady_idle", in_ready[0], 1);
        a_s[0]      = 32'hCAFEF00D;
        b_s[0]      = 32'h00001234;
        bin_s[0]    = 1'b1;
        in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero(0, "rst_mid");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid:inReady_rel", in_ready[0], 1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("rst_mid:no_stale_outValid", out_valid[0], 0);
        end

        // Sweep across slice widths: boundaries then randomised operands.
        for (int i = 0; i < NI; i++) begin
            run_op(i, 32'h00000000, 32'h00000001, 1'b0, 0, $sformatf("sw%0d_0m1", slice_of(i)));
            run_op(i, 32'h80000000, 32'h00000001, 1'b0, 1, $sformatf("sw%0d_minm1", slice_of(i)));
            run_op(i, 32'h12345678, 32'h12345678, 1'b0, 0, $sformatf("sw%0d_eq", slice_of(i)));
            for (int k = 0; k < 6; k++) begin
                ra = $urandom;
                rb = $urandom;
                run_op(i, ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                       $sformatf("sw%0d_rand%0d", slice_of(i), k));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor32.md
# serial_subtractor32

Multi-cycle 32-bit subtractor computing D = A − B − Bin, SLICE bits per clock, with valid/ready handshakes on both sides. It is the arithmetic counterpart of the team's 32-bit ripple adder and reports borrow-out and two's-complement overflow with the same flag semantics. It sits in the datapath wherever a low-area subtract or compare is acceptable at multi-cycle latency.

## Interface
- SLICE, 4, bits processed per cycle; legal values are 1, 2, 4, 8, 16, 32.
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- inValid  in  1  operand bundle valid
- inReady  out  1  block can accept an operand bundle
- A  in  32  minuend
- B  in  32  subtrahend
- Bin  in  1  borrow-in
- outValid  out  1  result valid
- outReady  in  1  consumer accepts the result
- D  out  32  difference
- Bout  out  1  borrow out of bit 31; 1 iff unsigned A < B + Bin
- overFlow  out  1  signed overflow
- zero  out  1  D == 0; present only with SUB_ZERO_FLAG_EN

## Operation
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - inReady = 1.
  - On inValid & inReady: latch A, B and Bin; clear the slice counter; go to RUN.
- RUN, each cycle:
  - Subtract the low SLICE bits of the A and B shift registers with the running borrow.
  - Shift both operand registers right by SLICE.
  - Shift the SLICE-bit difference into the top of the D register.
  - Register the borrow for the next slice.
  - Increment the counter.
- RUN exit: after N = 32/SLICE slices, register the final borrow as Bout and compute overFlow = (A[31] != B[31]) & (D[31] != A[31]) using the latched A[31] and B[31]. Go to HOLD.
- HOLD:
  - outValid = 1. D, Bout, overFlow (and zero) stay stable.
  - On outReady, go to IDLE.
- outValid is 0 in IDLE and RUN.
- inReady is 0 in RUN and HOLD. inValid is ignored in those states.
- A, B and Bin are sampled only on the accepting edge. outReady is ignored outside HOLD.
- All arithmetic is modulo 2^32.
- Reset (asynchronous, any state, including mid-RUN):
  - State goes to IDLE and the in-flight operation is discarded.
  - D, Bout, overFlow, zero, outValid and the counter reset to 0.
  - inReady is 1 from the first cycle after reset is released.

## Timing
- The accepting edge is T0. RUN occupies edges T0+1 … T0+N.
- outValid is high after edge T0+N. Latency is N cycles from acceptance.
- The HOLD→IDLE edge is the one where outValid & outReady are both high.
- The earliest next acceptance is one cycle later. Minimum throughput is one operation per N+2 cycles.
- SLICE=32 gives N=1, i.e. a single-cycle RUN.
- The combinational path is one SLICE-bit ripple-borrow chain plus register setup.

## Configuration
- Macro: SUB_ZERO_FLAG_EN.
- Defined:
  - Port zero exists.
  - zero is registered at RUN exit as (D == 0), stable through HOLD, and reset to 0.
- Undefined: no zero port and no extra logic. All other behaviour is identical.

## Structure
- Package sub_pkg holds:
  - WIDTH = 32.
  - The state typedef (IDLE, RUN, HOLD).
  - The legal-SLICE check constant.
- Sub-module sub_slice:
  - Combinational ripple-borrow chain of SLICE full subtractors, parameterised by width.
  - Ports: a, b, bin, d, bout.
  - Instantiated once. Top level holds the FSM, counter and shift registers.

## Test plan
- SLICE=4, A=5, B=3, Bin=0 → D=0x00000002, Bout=0, overFlow=0; outValid rises exactly 8 cycles after acceptance.
- A=0x00000000, B=0x00000001 → D=0xFFFFFFFF, Bout=1, overFlow=0.
- A=0x80000000, B=0x00000001 → D=0x7FFFFFFF, Bout=0, overFlow=1. A=0x7FFFFFFF, B=0xFFFFFFFF → D=0x80000000, Bout=1, overFlow=1.
- A=B=0x12345678:
  - Bin=1 → D=0xFFFFFFFF, Bout=1, zero=0.
  - Bin=0 → D=0, Bout=0, zero=1 (with SUB_ZERO_FLAG_EN).
- outReady held low for 5 cycles in HOLD → D and flags stable, outValid held at 1, inReady held at 0. The 2nd operation is accepted exactly one cycle after the handshake.
- rst_n asserted during slice 3 of RUN → all outputs 0 immediately, including mid-cycle. After release: inReady=1 and no stale outValid. Repeat the sweep for SLICE=1, 8 and 32 with randomised operands checked against a reference model.
